// File: rtl/clock_divider_pkg.sv
// ---------------------------------------------------------------------------
// clock_divider_pkg
// Shared constants and helper functions for the multi-channel clock divider.
//   DEF_W    : default divisor/counter width
//   DEF_DIV  : default divisor loaded at reset
//   MAX_W    : widest divisor the helper functions handle (W must not exceed it)
//   ceil_half: ceil(div/2) without overflow
//   clamp_div: maps a zero divisor to one
// ---------------------------------------------------------------------------
package clock_divider_pkg;

   localparam int DEF_W   = 32;
   localparam int DEF_DIV = 100;
   localparam int MAX_W   = 64;

   // (div >> 1) + div[0] never overflows, unlike (div + 1) >> 1
   function automatic logic [MAX_W-1:0] ceil_half(input logic [MAX_W-1:0] div);
      return (div >> 1) + {{(MAX_W-1){1'b0}}, div[0]};
   endfunction

   // A divisor of zero has no meaning; treat it as divide-by-one
   function automatic logic [MAX_W-1:0] clamp_div(input logic [MAX_W-1:0] div);
      return (div == '0) ? {{(MAX_W-1){1'b0}}, 1'b1} : div;
   endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// ---------------------------------------------------------------------------
// clock_divider_ch
// One divider channel: a period counter with an active divisor and a shadow
// divisor that is transferred at the period boundary so rate changes never
// produce a runt pulse on the divided clock.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active high
//   en      : count enable
//   wr      : divisor write strobe for this channel
//   wr_val  : divisor value to write (0 is treated as 1)
//   sync    : phase-align strobe (only with CLOCK_DIVIDER_SYNC_EN defined)
//   tick    : one-cycle pulse at the start of each period
//   div_clk : divided clock, high for ceil(div/2) of every div cycles
// Optional feature macro: CLOCK_DIVIDER_SYNC_EN
// ---------------------------------------------------------------------------
module clock_divider_ch
   import clock_divider_pkg::*;
#(
   parameter int          W       = DEF_W,
   parameter int unsigned DEF_DIV = clock_divider_pkg::DEF_DIV
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         wr,
   input  logic [W-1:0] wr_val,
`ifdef CLOCK_DIVIDER_SYNC_EN
   input  logic         sync,
`endif
   output logic         tick,
   output logic         div_clk
);

   logic [W-1:0] cnt;
   logic [W-1:0] div_act;
   logic [W-1:0] shadow;
   logic         pending;

   logic [W-1:0] val;
   logic [W-1:0] half;
   logic [W-1:0] cnt_nxt;
   logic         wrap;

   // Combinational helpers: clamped write value, the high-phase length of the
   // current divisor, the incremented count and the end-of-period flag.
   // cnt never exceeds div_act-1, so cnt+1 cannot overflow W bits.
   always_comb begin
      val     = W'(clamp_div(MAX_W'(wr_val)));
      half    = W'(ceil_half(MAX_W'(div_act)));
      cnt_nxt = cnt + W'(1);
      wrap    = (cnt == (div_act - W'(1)));
   end

   // Channel state. Priority: reset, then sync (if built in), then a write to
   // a stopped channel (applied at once, counter restarts), then normal
   // counting where a write to a running channel is parked in the shadow
   // register until the wrap. A write landing exactly on the wrap edge skips
   // the shadow and takes effect at that wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         div_act <= W'(DEF_DIV);
         shadow  <= '0;
         pending <= 1'b0;
         tick    <= 1'b0;
         div_clk <= 1'b0;
      end
`ifdef CLOCK_DIVIDER_SYNC_EN
      else if (sync) begin
         cnt     <= '0;
         tick    <= 1'b1;
         div_clk <= 1'b1;
         if (wr && !en) begin
            div_act <= val;
            pending <= 1'b0;
         end else if (pending) begin
            div_act <= shadow;
            pending <= 1'b0;
         end
      end
`endif
      else if (wr && !en) begin
         div_act <= val;
         cnt     <= '0;
         pending <= 1'b0;
         tick    <= 1'b0;
      end else if (en) begin
         if (wrap) begin
            cnt     <= '0;
            tick    <= 1'b1;
            div_clk <= 1'b1;
            if (wr) begin
               div_act <= val;
               pending <= 1'b0;
            end else if (pending) begin
               div_act <= shadow;
               pending <= 1'b0;
            end
         end else begin
            cnt  <= cnt_nxt;
            tick <= 1'b0;
            if (cnt_nxt == half) begin
               div_clk <= 1'b0;
            end
            if (wr) begin
               shadow  <= val;
               pending <= 1'b1;
            end
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
// Multi-channel runtime-programmable clock prescaler. Each of NCH channels
// produces a one-cycle tick and a near-50% divided clock from clk_i; the
// divisors are written through one shared port addressed by sel_i.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous reset, active high
//   en_i   : per-channel count enable
//   load_i : divisor write strobe (one cycle)
//   sel_i  : channel index for the write; indices >= NCH are ignored
//   div_i  : divisor value for the write (0 is treated as 1)
//   sync_i : phase-align all channels (only with CLOCK_DIVIDER_SYNC_EN)
//   tick_o : per-channel period tick
//   clk_o  : per-channel divided clock
// Optional feature macro: CLOCK_DIVIDER_SYNC_EN
// ---------------------------------------------------------------------------
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter int          NCH     = 2,
   parameter int          W       = DEF_W,
   parameter int unsigned DEF_DIV = clock_divider_pkg::DEF_DIV
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NCH-1:0]                          en_i,
   input  logic                                    load_i,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sel_i,
   input  logic [W-1:0]                            div_i,
`ifdef CLOCK_DIVIDER_SYNC_EN
   input  logic                                    sync_i,
`endif
   output logic [NCH-1:0]                          tick_o,
   output logic [NCH-1:0]                          clk_o
);

   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

   // One channel per enable bit. The write strobe is decoded by exact index
   // match, so an out-of-range sel_i matches no channel and is dropped.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic wr;

      assign wr = load_i && (sel_i == SW'(c));

      clock_divider_ch #(
         .W       (W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk     (clk_i),
         .rst     (rst_i),
         .en      (en_i[c]),
         .wr      (wr),
         .wr_val  (div_i),
`ifdef CLOCK_DIVIDER_SYNC_EN
         .sync    (sync_i),
`endif
         .tick    (tick_o[c]),
         .div_clk (clk_o[c])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_multi
// Directed bench for clock_divider_multi with three channels so that an
// out-of-range channel index (3) can be driven on the 2-bit select.
// ---------------------------------------------------------------------------
module tb_clock_divider_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  en;
   logic        load;
   logic [1:0]  sel;
   logic [31:0] div;
`ifdef CLOCK_DIVIDER_SYNC_EN
   logic        sync;
`endif
   logic [2:0]  tick;
   logic [2:0]  dclk;

   int assertCount = 0;
   int failCount   = 0;

   // Enable pattern and expected ch0 tick/clock for the pause test (div=6),
   // index 1 is the first edge after the divisor load
   logic [1:15] en0Pat   = 15'b110001111111111;
   logic [1:15] tickPat  = 15'b000000001000001;
   logic [1:15] clkPat   = 15'b111110001110001;

   clock_divider_multi #(
      .NCH     (3),
      .W       (32),
      .DEF_DIV (100)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (en),
      .load_i (load),
      .sel_i  (sel),
      .div_i  (div),
`ifdef CLOCK_DIVIDER_SYNC_EN
      .sync_i (sync),
`endif
      .tick_o (tick),
      .clk_o  (dclk)
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   // Safety net so the run always ends even if the sequence stalls
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive the inputs for the next edge, then advance to just after it
   task automatic applyStimulus(input logic r, input logic [2:0] e, input logic l,
                                input logic [1:0] s, input logic [31:0] d);
      rst  = r;
      en   = e;
      load = l;
      sel  = s;
      div  = d;
      @(posedge clk);
      #1;
   endtask

   // One counted comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
`ifdef CLOCK_DIVIDER_SYNC_EN
      sync = 1'b0;
`endif
      // Reset state
      applyStimulus(1'b1, 3'b000, 1'b0, 2'd0, 32'd0);
      applyStimulus(1'b1, 3'b000, 1'b0, 2'd0, 32'd0);
      checkOutput("reset_tick", 32'(tick), 32'd0);
      checkOutput("reset_clk", 32'(dclk), 32'd0);

      // Default divisor on ch0: first tick after 100 enabled edges
      for (int i = 1; i <= 100; i++) begin
         applyStimulus(1'b0, 3'b001, 1'b0, 2'd0, 32'd0);
         checkOutput("def_first_tick", 32'(tick[0]), 32'(i == 100));
         checkOutput("def_first_clk", 32'(dclk[0]), 32'(i == 100));
      end
      // Second period: clock high 50, low 50, tick at the end
      for (int j = 1; j <= 100; j++) begin
         applyStimulus(1'b0, 3'b001, 1'b0, 2'd0, 32'd0);
         checkOutput("def_tick", 32'(tick[0]), 32'(j == 100));
         checkOutput("def_clk", 32'(dclk[0]), 32'((j < 50) || (j == 100)));
      end
      checkOutput("idle_ch_tick", 32'(tick[2:1]), 32'd0);
      checkOutput("idle_ch_clk", 32'(dclk[2:1]), 32'd0);

      // Disabled load of div=4 on ch0: immediate, clock level holds
      applyStimulus(1'b0, 3'b000, 1'b1, 2'd0, 32'd4);
      checkOutput("dis_load_tick", 32'(tick[0]), 32'd0);
      checkOutput("dis_load_clk", 32'(dclk[0]), 32'd1);
      for (int j = 1; j <= 12; j++) begin
         applyStimulus(1'b0, 3'b001, 1'b0, 2'd0, 32'd0);
         checkOutput("div4_tick", 32'(tick[0]), 32'((j % 4) == 0));
         checkOutput("div4_clk", 32'(dclk[0]), 32'(((j % 4) == 0) || ((j % 4) == 1)));
      end

      // ch1 div=5, then div=3 at cnt=2 and div=2 at cnt=3: last write wins
      applyStimulus(1'b0, 3'b000, 1'b1, 2'd1, 32'd5);
      for (int k = 1; k <= 11; k++) begin
         applyStimulus(1'b0, 3'b010, (k == 3) || (k == 4), 2'd1, (k == 3) ? 32'd3 : 32'd2);
         checkOutput("shadow_tick", 32'(tick[1]),
                     32'((k == 5) || ((k > 5) && (((k - 5) % 2) == 0))));
         checkOutput("shadow_clk", 32'(dclk[1]),
                     32'((k == 5) || ((k > 5) && (((k - 5) % 2) == 0))));
      end
      checkOutput("stopped_ch0_tick", 32'(tick[0]), 32'd0);

      // div=0 on running ch1 is clamped to 1 and applied at the next wrap
      applyStimulus(1'b0, 3'b010, 1'b1, 2'd1, 32'd0);
      checkOutput("zero_load_tick", 32'(tick[1]), 32'd0);
      applyStimulus(1'b0, 3'b010, 1'b0, 2'd0, 32'd0);
      checkOutput("zero_wrap_tick", 32'(tick[1]), 32'd1);
      for (int j = 1; j <= 3; j++) begin
         applyStimulus(1'b0, 3'b010, 1'b0, 2'd0, 32'd0);
         checkOutput("div1_tick", 32'(tick[1]), 32'd1);
         checkOutput("div1_clk", 32'(dclk[1]), 32'd1);
      end

      // Write to sel=3 (out of range) must leave every channel untouched
      for (int m = 1; m <= 8; m++) begin
         applyStimulus(1'b0, 3'b111, (m == 1), 2'd3, 32'd7);
         checkOutput("oor_ch0_tick", 32'(tick[0]), 32'((m % 4) == 0));
         checkOutput("oor_ch1_tick", 32'(tick[1]), 32'd1);
         checkOutput("oor_ch2_tick", 32'(tick[2]), 32'd0);
      end

      // Pause ch0 for 3 edges mid-period with div=6: spacing becomes 9
      applyStimulus(1'b0, 3'b010, 1'b1, 2'd0, 32'd6);
      checkOutput("div6_load_tick", 32'(tick[0]), 32'd0);
      checkOutput("div6_load_clk", 32'(dclk[0]), 32'd1);
      for (int s = 1; s <= 15; s++) begin
         applyStimulus(1'b0, {1'b0, 1'b1, en0Pat[s]}, 1'b0, 2'd0, 32'd0);
         checkOutput("pause_tick", 32'(tick[0]), 32'(tickPat[s]));
         checkOutput("pause_clk", 32'(dclk[0]), 32'(clkPat[s]));
      end

      // Park div=3 in ch0 shadow, then reset: outputs clear, default returns
      applyStimulus(1'b0, 3'b011, 1'b1, 2'd0, 32'd3);
      checkOutput("pend_load_tick", 32'(tick[0]), 32'd0);
      applyStimulus(1'b1, 3'b011, 1'b1, 2'd0, 32'd3);
      checkOutput("mid_reset_tick", 32'(tick), 32'd0);
      checkOutput("mid_reset_clk", 32'(dclk), 32'd0);
      for (int i = 1; i <= 103; i++) begin
         applyStimulus(1'b0, 3'b001, 1'b0, 2'd0, 32'd0);
         checkOutput("post_reset_tick", 32'(tick[0]), 32'(i == 100));
      end

`ifdef CLOCK_DIVIDER_SYNC_EN
      // Sync pulse aligns every channel on the same edge
      sync = 1'b1;
      applyStimulus(1'b0, 3'b001, 1'b0, 2'd0, 32'd0);
      sync = 1'b0;
      checkOutput("sync_tick", 32'(tick), 32'd7);
      checkOutput("sync_clk", 32'(dclk), 32'd7);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
